// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one inverse-cipher core between two requesters.
// Caches the last expanded key so the key schedule is rerun only when the key changes.
module aes_core_arbiter #(
   parameter int NK      = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [127:0]     req0_data,
   input  logic [NK*32-1:0] req0_key,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [127:0]     req1_data,
   input  logic [NK*32-1:0] req1_key,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [127:0]     resp0_data,
   output logic             resp0_err,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [127:0]     resp1_data,
   output logic             resp1_err,
   output logic [NK*32-1:0] core_key,
   output logic             core_key_load,
   input  logic             core_key_done,
   output logic [127:0]     core_data,
   output logic             core_start,
   input  logic             core_done,
   input  logic [127:0]     core_result
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   // state | meaning
   // IDLE  | arbitrate and accept   KLOAD | key_load pulse   KWAIT | wait key_done
   // START | start pulse            DWAIT | wait core_done   RESP  | hold response
   typedef enum logic [2:0] {IDLE, KLOAD, KWAIT, START, DWAIT, RESP} state_t;

   state_t            state, state_next;
   logic              owner, last_grant, cache_valid;
   logic [NK*32-1:0]  cached_key;
   logic [TW-1:0]     timer;

   logic              grant0, grant1, key_hit, timer_last, owner_ready;
   logic              finish, abort;
   logic [NK*32-1:0]  sel_key;

   // last_grant names the requester served most recently; ties go to the other one
   assign grant0      = req0_valid && (!req1_valid || last_grant);
   assign grant1      = req1_valid && (!req0_valid || !last_grant);
   assign sel_key     = grant1 ? req1_key : req0_key;
   assign key_hit     = cache_valid && (sel_key == cached_key);
   assign timer_last  = (timer == T_LAST);
   assign owner_ready = owner ? resp1_ready : resp0_ready;

   assign finish = (state == DWAIT) && core_done;
   assign abort  = timer_last && (((state == KWAIT) && !core_key_done) ||
                                  ((state == DWAIT) && !core_done));

   assign req0_ready    = !reset && (state == IDLE) && grant0;
   assign req1_ready    = !reset && (state == IDLE) && grant1;
   assign core_key_load = (state == KLOAD);
   assign core_start    = (state == START);
   assign resp0_valid   = (state == RESP) && !owner;
   assign resp1_valid   = (state == RESP) && owner;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant0 || grant1) state_next = key_hit ? START : KLOAD;
         KLOAD:   state_next = KWAIT;
         KWAIT:   if (core_key_done) state_next = START;
                  else if (timer_last) state_next = RESP;
         START:   state_next = DWAIT;
         DWAIT:   if (core_done || timer_last) state_next = RESP;
         RESP:    if (owner_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_grant  <= 1'b1;
         cache_valid <= 1'b0;
         cached_key  <= '0;
         timer       <= '0;
         core_key    <= '0;
         core_data   <= '0;
         resp0_data  <= '0;
         resp0_err   <= 1'b0;
         resp1_data  <= '0;
         resp1_err   <= 1'b0;
      end else begin
         state <= state_next;

         if ((state == IDLE) && (grant0 || grant1)) begin
            owner      <= grant1;
            last_grant <= grant1;
            core_key   <= sel_key;
            core_data  <= grant1 ? req1_data : req0_data;
         end

         if ((state == KLOAD) || (state == START))
            timer <= '0;
         else if (((state == KWAIT) && !core_key_done) || ((state == DWAIT) && !core_done))
            timer <= timer + 1'b1;

         if ((state == KWAIT) && core_key_done) begin
            cached_key  <= core_key;
            cache_valid <= 1'b1;
         end else if (abort) begin
            cache_valid <= 1'b0;
         end

         if (finish || abort) begin
            if (owner) begin
               resp1_data <= finish ? core_result : '0;
               resp1_err  <= abort;
            end else begin
               resp0_data <= finish ? core_result : '0;
               resp0_err  <= abort;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a behavioural core that answers one
// cycle after each key_load/start pulse unless told to hang.
module tb_aes_core_arbiter;
   localparam int NK = 4;
   localparam int TO = 8;

   localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] D0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K1 = 128'h11111111111111111111111111111111;
   localparam logic [127:0] D1 = 128'h22222222222222222222222222222222;
   localparam logic [127:0] R1 = 128'h33333333333333333333333333333333;
   localparam logic [127:0] K2 = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
   localparam logic [127:0] D2 = 128'h55555555555555555555555555555555;
   localparam logic [127:0] R2 = 128'hffffffffffffffffffffffffffffffff;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req0_valid = 1'b0, req1_valid = 1'b0;
   logic req0_ready, req1_ready;
   logic [127:0] req0_data = '0, req1_data = '0;
   logic [NK*32-1:0] req0_key = '0, req1_key = '0;
   logic resp0_valid, resp1_valid;
   logic resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic [127:0] resp0_data, resp1_data;
   logic resp0_err, resp1_err;
   logic [NK*32-1:0] core_key;
   logic core_key_load, core_start;
   logic core_key_done, core_done;
   logic [127:0] core_data, core_result;

   bit hang = 1'b0, inject = 1'b0;
   bit kl_seen, st_seen;
   int kl_count, st_count;
   int errors = 0, checks = 0;
   int kl0, st0, cyc;
   logic [127:0] held;

   always #5 clk = ~clk;

   aes_core_arbiter #(.NK(NK), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_err(resp0_err),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_err(resp1_err),
      .core_key(core_key), .core_key_load(core_key_load), .core_key_done(core_key_done),
      .core_data(core_data), .core_start(core_start), .core_done(core_done), .core_result(core_result)
   );

   function automatic logic [127:0] plain(input logic [127:0] k, input logic [127:0] d);
      if (k == K0 && d == D0) return P0;
      return d ^ k;
   endfunction

   initial begin
      core_key_done = 1'b0;
      core_done = 1'b0;
      core_result = '0;
      kl_seen = 1'b0;
      st_seen = 1'b0;
      kl_count = 0;
      st_count = 0;
      forever begin
         @(negedge clk);
         core_key_done = kl_seen;
         core_done = st_seen | inject;
         if (st_seen) core_result = plain(core_key, core_data);
         kl_seen = (core_key_load === 1'b1);
         st_seen = (core_start === 1'b1) && !hang;
         if (core_key_load === 1'b1) kl_count++;
         if (core_start === 1'b1) st_count++;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: run did not complete, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_any(input int budget, output int n);
      n = 0;
      while (!(resp0_valid || resp1_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("resp_arrived", {127'd0, resp0_valid || resp1_valid}, 128'd1);
   endtask

   task automatic hs(input bit port);
      if (port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      @(posedge clk); #1;
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
   endtask

   initial begin
      // reset: ready forced low even with a valid request
      req0_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_key_load", core_key_load, 0);
      chk("rst_start", core_start, 0);
      chk("rst_resp0_valid", resp0_valid, 0);
      chk("rst_resp1_valid", resp1_valid, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_core_data", core_data, 0);
      chk("rst_resp0_data", resp0_data, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // uncached key on req0
      req0_key = K0; req0_data = D0; kl0 = kl_count; st0 = st_count;
      @(negedge clk);
      chk("s2_req0_ready", req0_ready, 1);
      chk("s2_req1_ready", req1_ready, 0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req0_data = 128'hdeadbeef;
      wait_any(30, cyc);
      chk("s2_latency", cyc, 5);
      chk("s2_resp1_valid", resp1_valid, 0);
      chk("s2_data", resp0_data, P0);
      chk("s2_err", resp0_err, 0);
      chk("s2_key_loads", kl_count - kl0, 1);
      chk("s2_starts", st_count - st0, 1);
      hs(0);
      chk("s2_valid_drop", resp0_valid, 0);

      // same key again: cache hit
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_data = D0; kl0 = kl_count; st0 = st_count;
      @(negedge clk);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_any(30, cyc);
      chk("s3_latency", cyc, 3);
      chk("s3_key_loads", kl_count - kl0, 0);
      chk("s3_starts", st_count - st0, 1);
      chk("s3_data", resp0_data, P0);
      hs(0);

      // both valid, alternating keys; last grant was req0 so req1 goes first
      req0_key = K1; req0_data = D1; req0_valid = 1'b1;
      req1_key = K2; req1_data = D2; req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bit g;
         g = (i % 2 == 0);
         kl0 = kl_count;
         wait_any(40, cyc);
         chk("s4_resp1_valid", resp1_valid, g);
         chk("s4_resp0_valid", resp0_valid, !g);
         if (g) chk("s4_resp1_data", resp1_data, R2);
         else   chk("s4_resp0_data", resp0_data, R1);
         chk("s4_key_load", kl_count - kl0, 1);
         chk("s4_ready_busy", {req0_ready, req1_ready}, 0);
         hs(g);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // hung core on a cached key
      @(posedge clk); #1;
      hang = 1'b1; req0_valid = 1'b1; st0 = st_count;
      @(negedge clk);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_any(40, cyc);
      chk("s5_latency", cyc, 10);
      chk("s5_err", resp0_err, 1);
      chk("s5_data", resp0_data, 0);
      chk("s5_starts", st_count - st0, 1);
      hs(0);
      hang = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b1; kl0 = kl_count;
      @(negedge clk);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_any(40, cyc);
      chk("s5_reload", kl_count - kl0, 1);
      chk("s5_retry_data", resp0_data, R1);
      chk("s5_retry_err", resp0_err, 0);
      hs(0);

      // response backpressure while req1 waits
      @(posedge clk); #1;
      req0_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b1;
      wait_any(30, cyc);
      chk("s6_latency", cyc, 3);
      held = resp0_data;
      chk("s6_held_data", held, R1);
      for (int k = 0; k < 5; k++) begin
         chk("s6_valid_hold", resp0_valid, 1);
         chk("s6_data_hold", resp0_data, held);
         chk("s6_req1_blocked", req1_ready, 0);
         @(negedge clk);
      end
      hs(0);
      chk("s6_req1_ready", req1_ready, 1);
      kl0 = kl_count;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_any(30, cyc);
      chk("s6_req1_latency", cyc, 5);
      chk("s6_resp0_idle", resp0_valid, 0);
      chk("s6_resp1_data", resp1_data, R2);
      chk("s6_key_load", kl_count - kl0, 1);
      hs(1);

      // reset during DWAIT, then a stray core_done in IDLE
      @(posedge clk); #1;
      hang = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("s7_resp0_valid", resp0_valid, 0);
      chk("s7_resp1_valid", resp1_valid, 0);
      chk("s7_start", core_start, 0);
      chk("s7_key_load", core_key_load, 0);
      chk("s7_core_key", core_key, 0);
      chk("s7_core_data", core_data, 0);
      chk("s7_resp1_data", resp1_data, 0);
      reset = 1'b0; hang = 1'b0; inject = 1'b1;
      repeat (3) @(negedge clk);
      inject = 1'b0;
      @(negedge clk);
      chk("s7_late_done_resp", {resp0_valid, resp1_valid}, 0);
      chk("s7_late_done_start", core_start, 0);
      @(posedge clk); #1;
      req1_valid = 1'b1; kl0 = kl_count;
      @(negedge clk);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_any(30, cyc);
      chk("s7_latency", cyc, 5);
      chk("s7_reload", kl_count - kl0, 1);
      chk("s7_data", resp1_data, R2);
      hs(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
